pc_npc_unit: RTL and testbench
==============================

Name: pc_npc_unit

Overview:
- Fetch-stage program counter for the single-cycle MIPS core.
- Holds the PC, which drives the instruction memory address input, and computes the next PC from the decoded branch/jump controls of the current instruction.
- Adds a run/halt/fault state machine and a retired-instruction counter for simulation bring-up against MARS.
- Directly upstream of the 4 KiB instruction memory, which uses addr[11:2].

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; matches the MARS text base.
- IM_WORDS, 1024, instruction memory depth in words. The legal PC window is [RESET_PC, RESET_PC + 4*IM_WORDS).

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle; no retire.
- halt_req  in  1  decoder saw the halt instruction (syscall).
- npc_sel  in  3  next-PC select; see Behaviour.
- zero  in  1  ALU zero flag for the current instruction.
- imm16  in  16  branch offset field.
- imm26  in  26  jump target field.
- rs_data  in  32  register rs value, used as the jr target.
- pc  out  32  current PC; feeds the instruction memory addr.
- pc_plus4  out  32  pc+4, combinational; jal link value.
- halted  out  1  FSM in HALT.
- fault  out  1  FSM in FAULT.
- fault_pc  out  32  PC of the instruction that faulted.
- retired  out  32  count of instructions that advanced the PC.

Behaviour:
- Reset values: pc=RESET_PC, state=RUN, halted=0, fault=0, fault_pc=0, retired=0. Reset wins over every other input in every state, including mid-halt and mid-fault.
- npc_sel encoding:
  - 0 PC4: pc+4.
  - 1 BEQ: taken when zero=1.
  - 2 BNE: taken when zero=0.
  - 3 J: jump target.
  - 4 JAL: jump target.
  - 5 JR: rs_data.
  - 6 and 7 are reserved and behave as PC4.
- Target arithmetic, all 32-bit modulo:
  - Branch target = pc_plus4 + (sign-extended imm16 << 2).
  - Jump target = {pc_plus4[31:28], imm26, 2'b00}.
  - An untaken branch selects pc_plus4.
- Latency: pc updates on the rising clk edge following the cycle in which controls are valid (single-cycle core; no delay slot).
- FSM states RUN, HALT, FAULT; priority order within RUN is reset > halt_req > fault check > stall > advance.
  - RUN, halt_req=1 (regardless of stall): go to HALT. pc holds; retired does not increment.
  - RUN, candidate next PC has bits[1:0]!=0 or lies outside the legal window: go to FAULT. pc holds, fault_pc<=pc, retired does not increment.
  - RUN, stall=1: pc holds, retired holds, stay RUN.
  - RUN, otherwise: pc<=next PC, retired<=retired+1.
  - HALT and FAULT are absorbing until reset. pc and retired are frozen.
- retired wraps from 32'hFFFF_FFFF to 0 with no flag.
- Outputs: halted and fault are registered state decodes. pc_plus4 is combinational from pc.

Decomposition:
- Package mips_fetch_pkg holds:
  - npc_sel constants NPC_PC4, NPC_BEQ, NPC_BNE, NPC_J, NPC_JAL, NPC_JR.
  - FSM state encodings S_RUN, S_HALT, S_FAULT.
  - The default RESET_PC.
- One combinational sub-module, npc_calc, takes pc_plus4, npc_sel, zero, imm16, imm26 and rs_data, and produces the candidate next PC.
- The top level keeps the PC register, FSM, range check and counter.

Test Plan:
- Reset then 3 cycles of npc_sel=0 -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C; retired=3.
- At pc=0x3008: BEQ, zero=1, imm16=16'hFFFE -> pc=0x3004. Same with zero=0 -> pc=0x300C. BNE, zero=0, imm16=16'h0003 -> pc=0x3018.
- At pc=0x3010: J with imm26=26'h0000C05 -> pc=0x3014. JR with rs_data=0x3020 -> pc=0x3020. JR with rs_data=0x3022 -> fault=1, fault_pc=0x3010, pc stays 0x3010. Raise stall for 2 cycles while in FAULT -> no change.
- Stall held 3 cycles at pc=0x3004 -> pc and retired frozen; on release, advances to 0x3008.
- halt_req and stall together at pc=0x300C -> halted=1 next edge; pc frozen at 0x300C thereafter. Assert reset while halted -> pc=0x3000, halted=0, retired=0.
- J with target 0x4000 (imm26=26'h0001000, outside 0x3000-0x3FFF) -> fault=1. Reserved npc_sel=7 -> behaves as PC4.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes, FSM states, reset PC.
// No logic of its own; latency not applicable.
// No flow control; constants and a helper function only.
package mips_fetch_pkg;

    // npc_sel encodings; 6 and 7 are reserved and fall back to sequential fetch
    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_BEQ = 3'd1;
    localparam logic [2:0] NPC_BNE = 3'd2;
    localparam logic [2:0] NPC_J   = 3'd3;
    localparam logic [2:0] NPC_JAL = 3'd4;
    localparam logic [2:0] NPC_JR  = 3'd5;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_t;

    // MARS places .text here, so the first instruction lives at this address
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Branch displacement in bytes: word offset sign-extended and scaled by 4
    function automatic logic [31:0] branch_disp(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Candidate next-PC mux: sequential, conditional branch, absolute jump or register jump.
// Purely combinational, zero cycles.
// No flow control; the caller decides whether the candidate is taken.
module npc_calc
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [2:0]  npc_sel,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic [31:0] npc
);

    logic [31:0] br_target;
    logic [31:0] j_target;

    assign br_target = pc_plus4 + branch_disp(imm16);
    // Jumps stay inside the 256 MiB region of the delay-slot-free successor
    assign j_target  = {pc_plus4[31:28], imm26, 2'b00};

    // Select the candidate; untaken branches and reserved codes fall through to pc+4
    always_comb begin
        npc = pc_plus4;
        case (npc_sel)
            NPC_BEQ: npc = zero  ? br_target : pc_plus4;
            NPC_BNE: npc = !zero ? br_target : pc_plus4;
            NPC_J,
            NPC_JAL: npc = j_target;
            NPC_JR:  npc = rs_data;
            default: npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_npc_unit.sv
// Fetch PC register with run/halt/fault control and a retired-instruction counter.
// PC updates on the clock edge after controls are valid; pc_plus4 is combinational.
// stall holds PC and counter; HALT and FAULT freeze everything until reset.
module pc_npc_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt_req,
    input  logic [2:0]  npc_sel,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] retired
);

    // Window bounds kept at 33 bits so a window touching 2^32 cannot wrap
    localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
    localparam logic [32:0] PC_HI = PC_LO + 33'(4 * IM_WORDS);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  retired_q, retired_d;
    logic         halted_q, halted_d;
    logic         fault_q, fault_d;

    logic [31:0]  npc;
    logic         npc_ok;

    assign pc_plus4 = pc_q + 32'd4;

    npc_calc u_npc_calc (
        .pc_plus4 (pc_plus4),
        .npc_sel  (npc_sel),
        .zero     (zero),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_data  (rs_data),
        .npc      (npc)
    );

    // A candidate is fetchable only if word-aligned and inside instruction memory
    always_comb begin
        npc_ok = (npc[1:0] == 2'b00)
              && ({1'b0, npc} >= PC_LO)
              && ({1'b0, npc} <  PC_HI);
    end

    // Next-state logic: halt beats fault, fault beats stall, stall beats advance
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        retired_d  = retired_q;
        case (state_q)
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (!npc_ok) begin
                    state_d    = S_FAULT;
                    fault_pc_d = pc_q;
                end else if (!stall) begin
                    pc_d      = npc;
                    retired_d = retired_q + 32'd1;
                end
            end
            default: begin
                // HALT and FAULT are absorbing; only reset leaves them
            end
        endcase
        halted_d = (state_d == S_HALT);
        fault_d  = (state_d == S_FAULT);
    end

    // State register with registered halted/fault decodes; reset overrides all inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= 32'd0;
            retired_q  <= 32'd0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            retired_q  <= retired_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign pc       = pc_q;
    assign halted   = halted_q;
    assign fault    = fault_q;
    assign fault_pc = fault_pc_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_pc_npc_unit.sv
module tb_pc_npc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, halt_req, zero;
    logic [2:0]  npc_sel;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic [31:0] pc, pc_plus4, fault_pc, retired;
    logic        halted, fault;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_fault_pc, m_retired;
    logic        m_halted, m_fault;

    localparam longint WIN_LO = 64'h3000;
    localparam longint WIN_HI = 64'h3000 + 4 * 1024;

    pc_npc_unit dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .halt_req (halt_req),
        .npc_sel  (npc_sel),
        .zero     (zero),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_data  (rs_data),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .halted   (halted),
        .fault    (fault),
        .fault_pc (fault_pc),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Where the instruction would go next, straight from the ISA description
    function automatic logic [31:0] ref_target(input int sel, input logic z, input logic [15:0] i16,
                                               input logic [25:0] i26, input logic [31:0] rs,
                                               input logic [31:0] cur);
        longint seq, off;
        seq = (longint'(cur) + 4) % (64'd1 << 32);
        off = longint'($signed(i16)) * 4;
        case (sel)
            1: return z  ? 32'(seq + off) : 32'(seq);
            2: return !z ? 32'(seq + off) : 32'(seq);
            3, 4: return 32'((seq / 64'h1000_0000) * 64'h1000_0000 + longint'(i26) * 4);
            5: return rs;
            default: return 32'(seq);
        endcase
    endfunction

    function automatic bit ref_legal(input logic [31:0] a);
        longint v;
        v = longint'(a);
        return (v % 4 == 0) && (v >= WIN_LO) && (v < WIN_HI);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pc"},       pc,                m_pc);
        chk({tag, ".halted"},   {31'd0, halted},   {31'd0, m_halted});
        chk({tag, ".fault"},    {31'd0, fault},    {31'd0, m_fault});
        chk({tag, ".fault_pc"}, fault_pc,          m_fault_pc);
        chk({tag, ".retired"},  retired,           m_retired);
    endtask

    // One clock of stimulus: drive, check combinational pc+4, clock, update model, compare
    task automatic step(input string tag, input logic [2:0] s, input logic z, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] rs, input logic st,
                        input logic hr, input logic rst);
        logic [31:0] tgt;
        npc_sel = s; zero = z; imm16 = i16; imm26 = i26; rs_data = rs;
        stall = st; halt_req = hr; reset = rst;
        #1;
        if (!rst) chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        tgt = ref_target(int'(s), z, i16, i26, rs, m_pc);
        @(posedge clk);
        #1;
        if (rst) begin
            m_pc = 32'h3000; m_halted = 0; m_fault = 0; m_fault_pc = 0; m_retired = 0;
        end else if (!m_halted && !m_fault) begin
            if (hr) m_halted = 1;
            else if (!ref_legal(tgt)) begin
                m_fault = 1; m_fault_pc = m_pc;
            end else if (!st) begin
                m_pc = tgt; m_retired = m_retired + 1;
            end
        end
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 3'd3, 1'b1, 16'hFFFF, 26'h3FFFFFF, 32'h1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic seq4(input string tag);
        step(tag, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jr(input string tag, input logic [31:0] a);
        step(tag, 3'd5, 1'b0, 16'h0, 26'h0, a, 1'b0, 1'b0, 1'b0);
    endtask

    logic [2:0]  r_sel;
    logic [15:0] r_i16;
    logic [25:0] r_i26;
    logic [31:0] r_rs;
    logic [7:0]  r_b;
    logic        r_z, r_st, r_hr, r_rst;

    initial begin
        m_pc = 0; m_halted = 0; m_fault = 0; m_fault_pc = 0; m_retired = 0;
        reset = 1; stall = 0; halt_req = 0; zero = 0; npc_sel = 0;
        imm16 = 0; imm26 = 0; rs_data = 0;
        #2;
        do_reset("rst0");
        chk("tp_reset_pc", pc, 32'h3000);
        seq4("pc4_a"); seq4("pc4_b"); seq4("pc4_c");
        chk("tp_seq_pc", pc, 32'h300C);
        chk("tp_seq_ret", retired, 32'd3);

        jr("to3008_a", 32'h3008);
        step("beq_taken", 3'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("tp_beq_taken", pc, 32'h3004);
        jr("to3008_b", 32'h3008);
        step("beq_nt", 3'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("tp_beq_nt", pc, 32'h300C);
        jr("to3008_c", 32'h3008);
        step("bne_taken", 3'd2, 1'b0, 16'h0003, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("tp_bne", pc, 32'h3018);
        jr("to3010_a", 32'h3010);
        step("j", 3'd3, 1'b0, 16'h0, 26'h0000C05, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("tp_j", pc, 32'h3014);

        jr("to3004", 32'h3004);
        for (int i = 0; i < 3; i++)
            step("stall", 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("tp_stall_pc", pc, 32'h3004);
        seq4("unstall");
        chk("tp_unstall_pc", pc, 32'h3008);

        jr("to3010_b", 32'h3010);
        jr("jr3020", 32'h3020);
        chk("tp_jr", pc, 32'h3020);
        jr("to3010_c", 32'h3010);
        jr("jr_unaligned", 32'h3022);
        chk("tp_fault", {31'd0, fault}, 32'd1);
        chk("tp_fault_pc", fault_pc, 32'h3010);
        step("flt_stall0", 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step("flt_stall1", 3'd5, 1'b0, 16'h0, 26'h0, 32'h3000, 1'b1, 1'b1, 1'b0);
        chk("tp_fault_hold", pc, 32'h3010);

        do_reset("rst1");
        seq4("h_a"); seq4("h_b"); seq4("h_c");
        step("halt_stall", 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("tp_halted", {31'd0, halted}, 32'd1);
        seq4("halt_hold0");
        jr("halt_hold1", 32'h3100);
        chk("tp_halt_pc", pc, 32'h300C);
        do_reset("rst_halt");
        chk("tp_rst_ret", retired, 32'd0);

        step("j4000", 3'd3, 1'b0, 16'h0, 26'h0001000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("tp_j_oob", {31'd0, fault}, 32'd1);
        do_reset("rst2");
        step("sel7", 3'd7, 1'b1, 16'h0010, 26'h0000C40, 32'h3100, 1'b0, 1'b0, 1'b0);
        chk("tp_sel7", pc, 32'h3004);
        step("sel6", 3'd6, 1'b0, 16'h0010, 26'h0000C40, 32'h3100, 1'b0, 1'b0, 1'b0);
        jr("to3ffc", 32'h3FFC);
        seq4("wrap_oob");
        chk("tp_top_oob", {31'd0, fault}, 32'd1);
        do_reset("rst3");
        jr("below_win", 32'h2FFC);

        // Randomized run against the model
        do_reset("rst_rand");
        for (int i = 0; i < 800; i++) begin
            r_sel = 3'($urandom_range(0, 7));
            r_z   = 1'($urandom_range(0, 1));
            r_b   = 8'($urandom);
            r_i16 = {{8{r_b[7]}}, r_b};
            r_i26 = 26'(32'hC00 + $urandom_range(0, 1100));
            r_rs  = 32'h3000 + $urandom_range(0, 4200);
            r_st  = ($urandom_range(0, 3) == 0);
            r_hr  = ($urandom_range(0, 40) == 0);
            r_rst = (m_halted || m_fault) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 99) == 0);
            step("rand", r_sel, r_z, r_i16, r_i26, r_rs, r_st, r_hr, r_rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
